// File: rtl/dsp_mac_pipe.sv
// Pipelined framed multiply-accumulate: out = (C + sum A*B) >>> OUT_SHIFT, one result per frame.
// Define DSP_MAC_SAT_EN to clamp out-of-range results; otherwise they are truncated.
module dsp_mac_pipe #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int C_WIDTH   = 32,
    parameter int ACC_WIDTH = 48,
    parameter int P_WIDTH   = 16,
    parameter int OUT_SHIFT = 0,
    parameter int A_SIGNED  = 1,
    parameter int B_SIGNED  = 1,
    parameter int C_SIGNED  = 1,
    parameter int IN_REG    = 1,
    parameter int M_REG     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               in_valid,
    input  logic               in_first,
    input  logic               in_last,
    input  logic [A_WIDTH-1:0] a_in,
    input  logic [B_WIDTH-1:0] b_in,
    input  logic [C_WIDTH-1:0] c_in,
    output logic               out_valid,
    output logic [P_WIDTH-1:0] out_p,
    output logic               out_ovf
);
    localparam int AX_W = A_WIDTH + 1;
    localparam int BX_W = B_WIDTH + 1;
    localparam int PR_W = AX_W + BX_W;
    localparam int IN_W = 2 + C_WIDTH + A_WIDTH + B_WIDTH;
    localparam int M_W  = 2 + C_WIDTH + ACC_WIDTH;

    // ---------------- input register chain ----------------
    logic [IN_W-1:0] w_in_bus;
    logic [IN_W-1:0] w_s1_bus;
    logic            w_s1_valid;

    assign w_in_bus = {in_first, in_last, c_in, a_in, b_in};

    generate
        if (IN_REG == 0) begin : g_in_bypass
            assign w_s1_bus   = w_in_bus;
            assign w_s1_valid = in_valid;
        end else begin : g_in_regs
            logic [IN_REG*IN_W-1:0] r_in_bus;
            logic [IN_REG-1:0]      r_in_vld;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_in_vld <= '0;
                end else if (ce) begin
                    r_in_vld <= IN_REG'({r_in_vld, in_valid});
                end
            end

            // Data carries no reset so it can live in the DSP A/B input registers.
            always_ff @(posedge clk) begin
                if (ce) begin
                    r_in_bus <= (IN_REG*IN_W)'({r_in_bus, w_in_bus});
                end
            end

            assign w_s1_bus   = r_in_bus[IN_REG*IN_W-1 -: IN_W];
            assign w_s1_valid = r_in_vld[IN_REG-1];
        end
    endgenerate

    // ---------------- multiplier ----------------
    logic               w_s1_first;
    logic               w_s1_last;
    logic [C_WIDTH-1:0] w_s1_c;
    logic [A_WIDTH-1:0] w_s1_a;
    logic [B_WIDTH-1:0] w_s1_b;

    assign {w_s1_first, w_s1_last, w_s1_c, w_s1_a, w_s1_b} = w_s1_bus;

    logic signed [AX_W-1:0] w_a_x;
    logic signed [BX_W-1:0] w_b_x;
    logic signed [PR_W-1:0] w_prod_full;
    logic [ACC_WIDTH-1:0]   w_prod;

    assign w_a_x       = {(A_SIGNED != 0) & w_s1_a[A_WIDTH-1], w_s1_a};
    assign w_b_x       = {(B_SIGNED != 0) & w_s1_b[B_WIDTH-1], w_s1_b};
    assign w_prod_full = w_a_x * w_b_x;

    generate
        if (PR_W >= ACC_WIDTH) begin : g_prod_trunc
            assign w_prod = w_prod_full[ACC_WIDTH-1:0];
        end else begin : g_prod_ext
            assign w_prod = {{(ACC_WIDTH-PR_W){w_prod_full[PR_W-1]}}, w_prod_full};
        end
    endgenerate

    // ---------------- product register ----------------
    logic [M_W-1:0] w_m_in_bus;
    logic [M_W-1:0] w_m_bus;
    logic           w_m_valid;

    assign w_m_in_bus = {w_s1_first, w_s1_last, w_s1_c, w_prod};

    generate
        if (M_REG == 0) begin : g_m_bypass
            assign w_m_bus   = w_m_in_bus;
            assign w_m_valid = w_s1_valid;
        end else begin : g_m_reg
            logic [M_W-1:0] r_m_bus;
            logic           r_m_vld;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_m_vld <= 1'b0;
                end else if (ce) begin
                    r_m_vld <= w_s1_valid;
                end
            end

            always_ff @(posedge clk) begin
                if (ce) begin
                    r_m_bus <= w_m_in_bus;
                end
            end

            assign w_m_bus   = r_m_bus;
            assign w_m_valid = r_m_vld;
        end
    endgenerate

    logic                 w_m_first;
    logic                 w_m_last;
    logic [C_WIDTH-1:0]   w_m_c;
    logic [ACC_WIDTH-1:0] w_m_prod;
    logic [ACC_WIDTH-1:0] w_c_ext;

    assign {w_m_first, w_m_last, w_m_c, w_m_prod} = w_m_bus;

    generate
        if (C_WIDTH == ACC_WIDTH) begin : g_c_full
            assign w_c_ext = w_m_c;
        end else begin : g_c_ext
            assign w_c_ext = {{(ACC_WIDTH-C_WIDTH){(C_SIGNED != 0) & w_m_c[C_WIDTH-1]}}, w_m_c};
        end
    endgenerate

    // ---------------- accumulator ----------------
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] w_acc_next;
    logic                 r_acc_load;

    assign w_acc_next = (w_m_first ? w_c_ext : r_acc) + w_m_prod;

    // r_acc_load marks that r_acc now holds a completed frame for the output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_acc_load <= 1'b0;
        end else if (ce) begin
            r_acc_load <= w_m_valid & w_m_last;
            if (w_m_valid) begin
                r_acc <= w_acc_next;
            end
        end
    end

    // ---------------- shift, range check, output register ----------------
    logic signed [ACC_WIDTH-1:0] w_shr;
    logic [ACC_WIDTH-P_WIDTH:0]  w_hi;
    logic                        w_ovf;
    logic [P_WIDTH-1:0]          w_p;

    assign w_shr = $signed(r_acc) >>> OUT_SHIFT;
    assign w_hi  = w_shr[ACC_WIDTH-1:P_WIDTH-1];
    // In range only when every bit above the result sign bit matches it.
    assign w_ovf = ~((&w_hi) | ~(|w_hi));

`ifdef DSP_MAC_SAT_EN
    always_comb begin
        w_p = w_shr[P_WIDTH-1:0];
        if (w_ovf) begin
            w_p = w_shr[ACC_WIDTH-1] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                                     : {1'b0, {(P_WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_p = w_shr[P_WIDTH-1:0];
`endif

    logic               r_out_valid;
    logic [P_WIDTH-1:0] r_out_p;
    logic               r_out_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_p     <= '0;
            r_out_ovf   <= 1'b0;
        end else if (ce) begin
            r_out_valid <= r_acc_load;
            if (r_acc_load) begin
                r_out_p   <= w_p;
                r_out_ovf <= w_ovf;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_p     = r_out_p;
    assign out_ovf   = r_out_ovf;

endmodule

// File: doc/dsp_mac_pipe.md
# dsp_mac_pipe

Parametrised, pipelined multiply-accumulate engine and the successor to the single-DSP48E2 wrapper. It computes framed dot products, `C + Σ A·B`, over bursts of operand beats marked with first/last flags. Valid tracking runs through a configurable pipeline, and the shifted, width-reduced result is produced once per frame. The block is written behaviourally so that synthesis maps the multiplier, pipeline and accumulator onto DSP48E2 M/P registers. It sits between the GEMM operand streamers and the result writeback.

## Interface
Parameters:
- `A_WIDTH`, 16: A operand width (≤27).
- `B_WIDTH`, 16: B operand width (≤18).
- `C_WIDTH`, 32: bias width (≤ACC_WIDTH).
- `ACC_WIDTH`, 48: accumulator width.
- `P_WIDTH`, 16: result width.
- `OUT_SHIFT`, 0: right arithmetic shift applied to the accumulator before width reduction (0..ACC_WIDTH-P_WIDTH).
- `A_SIGNED`, `B_SIGNED`, `C_SIGNED`, 1: operand signedness; 0 means zero-extend.
- `IN_REG`, 1: input register stages, 0..2.
- `M_REG`, 1: product register stages, 0..1.

Ports:
- `clk` in, 1: clock.
- `rst` in, 1: synchronous, active-high reset; takes priority over `ce`.
- `ce` in, 1: global clock enable; when low, every register holds.
- `in_valid` in, 1: operand beat valid.
- `in_first` in, 1: first beat of a frame.
- `in_last` in, 1: last beat of a frame.
- `a_in` in, A_WIDTH: multiplicand.
- `b_in` in, B_WIDTH: multiplier.
- `c_in` in, C_WIDTH: bias. Sampled on the first beat only.
- `out_valid` out, 1: result valid.
- `out_p` out, P_WIDTH: result.
- `out_ovf` out, 1: the reduced result did not represent the accumulator exactly.

## Operation
- Operands are extended to ACC_WIDTH according to their signedness flags. The product is an exact ACC_WIDTH two's-complement value.
- Beats, with the flags and `c_in`, travel through IN_REG + M_REG stages. The accumulator stage is always registered.
- Accumulator update on a valid beat:
  - `in_first` = 1: `acc ← ext(c) + prod`.
  - `in_first` = 0: `acc ← acc + prod`.
  - All arithmetic wraps modulo 2^ACC_WIDTH. There is no overflow detection inside the accumulator.
- Beats with `in_valid` = 0 are bubbles. They leave `acc` unchanged and do not break the frame.
- On a valid beat with `in_last` = 1, the output register loads:
  - `r = acc_next >>> OUT_SHIFT` (arithmetic shift).
  - `out_p = r[P_WIDTH-1:0]`.
  - `out_ovf = 1` if `r` is outside the signed P_WIDTH range, else 0.
- `out_valid` is set for a loading beat and cleared on any other ce-enabled cycle. A result is consumed on a cycle where `out_valid` & `ce` are both high.
- `in_first` and `in_last` on the same beat form a one-beat frame, result `c + a·b`.
- A valid beat without `in_first` arriving after a completed frame continues accumulating onto the previous `acc`. This is defined behaviour; the producer must frame correctly.
- A frame that has not yet seen `in_last` produces no output.
- Reset mid-frame discards the frame.

## Timing
- Latency from a valid beat with `in_last` (sampled with `ce` = 1) to `out_valid` is IN_REG + M_REG + 2 ce-enabled cycles: the accumulator stage plus the output stage.
- Throughput is one beat per ce-enabled cycle. There is no backpressure other than `ce`.
- `ce` = 0 freezes all stages, including `out_valid` and `out_p`, for any number of cycles. No beat is lost or duplicated.
- Reset values: `out_valid` = 0, `out_p` = 0, `out_ovf` = 0, `acc` = 0, all pipeline valid bits = 0. Reset clears them on the next `clk` edge regardless of `ce`.
- Back-to-back frames are supported, where `in_first` immediately follows `in_last`. Results come out on consecutive cycles for one-beat frames.

## Configuration
- `DSP_MAC_SAT_EN` defined: when `r` is out of range, `out_p` clamps to 2^(P_WIDTH-1)-1 or -2^(P_WIDTH-1); `out_ovf` still flags the event.
- `DSP_MAC_SAT_EN` undefined: `out_p` is the plain truncation `r[P_WIDTH-1:0]`; `out_ovf` behaves the same.

## Test plan
- **Basic frame:** defaults, frame of (3·4), (−2·5), (7·1) with c = 10 -> `out_valid` at latency 4 after the last beat, `out_p` = 19, `out_ovf` = 0.
- **One-beat frames back to back:** (1·1, c=0), (2·2, c=1), (−3·3, c=0) -> three consecutive results 1, 5, −9.
- **Stall and bubbles:** `ce` held low for 5 cycles mid-frame, `in_valid` gaps inserted -> result identical to the unstalled run, latency extended by exactly 5 cycles.
- **Overflow:** P_WIDTH = 16, frame 200·200 + 100·100 = 50000 -> without the macro `out_p` = −15536 with `out_ovf` = 1; with `DSP_MAC_SAT_EN` `out_p` = 32767 with `out_ovf` = 1.
- **Shift and unsigned operands:** OUT_SHIFT = 4, A/B unsigned, 65535·16 -> `out_p` = 65535 truncated to −1 with `out_ovf` = 1; 255·16 -> `out_p` = 255.
- **Reset mid-frame:** assert `rst` for one cycle between beats 2 and 3, then send a fresh frame (5·5, c=0) -> no output for the aborted frame; `out_p` = 25; outputs are 0 during reset.
